// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, polarity normalisation, per-button debounce FSM
// with press/release strobes. Define BTN_DEBOUNCE_TOGGLE_EN to add the btn_toggle output.
module btn_debounce #(
  parameter int                 N_BTN           = 7,
  parameter int                 DEBOUNCE_CYCLES = 250000,
  parameter logic [N_BTN-1:0]   ACTIVE_LOW_MASK = 7'b0000001
) (
  input  logic             clk_25mhz,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
`ifdef BTN_DEBOUNCE_TOGGLE_EN
  ,
  output logic [N_BTN-1:0] btn_toggle
`endif
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESSED = 1'b1
  } state_t;

  logic [N_BTN-1:0] sync1_reg;
  logic [N_BTN-1:0] sync2_reg;
  logic [N_BTN-1:0] sample;

  // Reset loads the mask so the normalised sample reads idle straight out of reset.
  always_ff @(posedge clk_25mhz) begin
    if (!rst_n) begin
      sync1_reg <= ACTIVE_LOW_MASK;
      sync2_reg <= ACTIVE_LOW_MASK;
    end else begin
      sync1_reg <= btn_raw;
      sync2_reg <= sync1_reg;
    end
  end

  assign sample = sync2_reg ^ ACTIVE_LOW_MASK;

  generate
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
      state_t           state_reg, state_next;
      logic [CNT_W-1:0] cnt_reg, cnt_next;
      logic             press_reg, press_next;
      logic             release_reg, release_next;
      logic             level_now;

      assign level_now = (state_reg == PRESSED);

      always_ff @(posedge clk_25mhz) begin
        if (!rst_n) begin
          state_reg   <= IDLE;
          cnt_reg     <= '0;
          press_reg   <= 1'b0;
          release_reg <= 1'b0;
        end else begin
          state_reg   <= state_next;
          cnt_reg     <= cnt_next;
          press_reg   <= press_next;
          release_reg <= release_next;
        end
      end

      // Counter only runs while the sample disagrees with the level; any agreement forgets it.
      always_comb begin
        state_next   = state_reg;
        cnt_next     = '0;
        press_next   = 1'b0;
        release_next = 1'b0;
        if (sample[gi] != level_now) begin
          if (cnt_reg == CNT_LAST) begin
            state_next   = sample[gi] ? PRESSED : IDLE;
            press_next   = sample[gi];
            release_next = ~sample[gi];
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end

      assign btn_level[gi]   = level_now;
      assign btn_press[gi]   = press_reg;
      assign btn_release[gi] = release_reg;
    end
  endgenerate

`ifdef BTN_DEBOUNCE_TOGGLE_EN
  logic [N_BTN-1:0] toggle_reg;

  always_ff @(posedge clk_25mhz) begin
    if (!rst_n) begin
      toggle_reg <= '0;
    end else begin
      toggle_reg <= toggle_reg ^ btn_press;
    end
  end

  assign btn_toggle = toggle_reg;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce: directed scenarios with literal expectations plus
// randomized bouncing compared every cycle against a sliding-window behavioural model.
module tb_btn_debounce;

  localparam int           N    = 7;
  localparam int           DC   = 4;
  localparam logic [N-1:0] MASK = 7'b0000001;

  logic         clk_25mhz = 1'b0;
  logic         rst_n;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;
`ifdef BTN_DEBOUNCE_TOGGLE_EN
  logic [N-1:0] btn_toggle;
`endif

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  btn_debounce #(
    .N_BTN          (N),
    .DEBOUNCE_CYCLES(DC),
    .ACTIVE_LOW_MASK(MASK)
  ) dut (
    .clk_25mhz  (clk_25mhz),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
`ifdef BTN_DEBOUNCE_TOGGLE_EN
    ,
    .btn_toggle (btn_toggle)
`endif
  );

  always #20 clk_25mhz = ~clk_25mhz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_25mhz);
  endtask

  // Model: a change is accepted once the last DC synchronised samples all disagree with the level.
  logic [N-1:0]  m_level, m_press, m_rel, m_tog;
  logic [N-1:0]  cap1, cap2, seen;
  logic [DC-1:0] win [N];
  int            nvalid;

  always @(posedge clk_25mhz) begin
    if (!rst_n) begin
      cap1 = '0; cap2 = '0; nvalid = 0;
      m_level = '0; m_press = '0; m_rel = '0; m_tog = '0;
      for (int i = 0; i < N; i++) win[i] = '0;
    end else begin
      seen = cap2;
      cap2 = cap1;
      cap1 = btn_raw ^ MASK;
      m_tog = m_tog ^ m_press;
      m_press = '0;
      m_rel   = '0;
      if (nvalid < DC) nvalid++;
      for (int i = 0; i < N; i++) begin
        win[i] = {win[i][DC-2:0], seen[i]};
        if (nvalid == DC && win[i] == {DC{~m_level[i]}}) begin
          m_level[i] = seen[i];
          if (seen[i]) m_press[i] = 1'b1;
          else         m_rel[i]   = 1'b1;
        end
      end
    end
  end

  always @(negedge clk_25mhz) begin
    if (chk_en) begin
      check("cyc_level",   32'(btn_level),   32'(m_level));
      check("cyc_press",   32'(btn_press),   32'(m_press));
      check("cyc_release", 32'(btn_release), 32'(m_rel));
`ifdef BTN_DEBOUNCE_TOGGLE_EN
      check("cyc_toggle",  32'(btn_toggle),  32'(m_tog));
`endif
    end
  end

  int hold [N];

  initial begin
    rst_n   = 1'b0;
    btn_raw = 7'b0000001;
    @(posedge clk_25mhz);
    #1 chk_en = 1'b1;

    // Reset held, then six idle cycles after release
    for (int c = 0; c < 3; c++) begin
      tick(1);
      check("rst_level", 32'(btn_level), 32'h0);
      check("rst_strobe", 32'(btn_press | btn_release), 32'h0);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick(1);
      check("post_rst_level", 32'(btn_level | btn_press | btn_release), 32'h0);
    end

    // Clean press/release on btn[3]
    btn_raw[3] = 1'b1;
    tick(5);
    check("press3_early", 32'(btn_level), 32'h0);
    tick(1);
    check("press3_level", 32'(btn_level), 32'h08);
    check("press3_strobe", 32'(btn_press), 32'h08);
    check("model_press3", 32'(m_press), 32'h08);
    tick(1);
    check("press3_one_cycle", 32'(btn_press), 32'h0);
    check("press3_steady", 32'(btn_level), 32'h08);
    btn_raw[3] = 1'b0;
    tick(6);
    check("release3_strobe", 32'(btn_release), 32'h08);
    check("release3_level", 32'(btn_level), 32'h0);
    tick(2);

    // Glitch of DC-1 cycles rejected, DC cycles accepted
    btn_raw[2] = 1'b1;
    tick(3);
    btn_raw[2] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick(1);
      check("glitch_reject", 32'(btn_level | btn_press), 32'h0);
    end
    btn_raw[2] = 1'b1;
    tick(4);
    btn_raw[2] = 1'b0;
    tick(2);
    check("glitch4_press", 32'(btn_press), 32'h04);
    check("glitch4_level", 32'(btn_level), 32'h04);
    tick(4);
    check("glitch4_release", 32'(btn_release), 32'h04);
    check("glitch4_low", 32'(btn_level), 32'h0);
    tick(2);

    // Active-low btn[0]
    btn_raw[0] = 1'b0;
    tick(6);
    check("pwr_press", 32'(btn_press), 32'h01);
    check("pwr_level", 32'(btn_level), 32'h01);
    btn_raw[0] = 1'b1;
    tick(6);
    check("pwr_release", 32'(btn_release), 32'h01);
    check("pwr_low", 32'(btn_level), 32'h0);
    tick(2);

    // Simultaneous rise on btn[6:4]
    btn_raw[6:4] = 3'b111;
    tick(6);
    check("simul_press", 32'(btn_press), 32'h70);
    check("model_simul", 32'(m_press), 32'h70);
    btn_raw[6:4] = 3'b000;
    tick(8);

    // Reset two cycles into a count, button kept held
    btn_raw[5] = 1'b1;
    tick(4);
    rst_n = 1'b0;
    tick(2);
    check("midrst_level", 32'(btn_level | btn_press | btn_release), 32'h0);
    rst_n = 1'b1;
    tick(5);
    check("midrst_wait", 32'(btn_level | btn_press), 32'h0);
    tick(1);
    check("midrst_press", 32'(btn_press), 32'h20);
    check("midrst_level2", 32'(btn_level), 32'h20);
    btn_raw[5] = 1'b0;
    tick(8);

    // Three presses of btn[1]; toggle follows one cycle after each press strobe
    for (int p = 0; p < 3; p++) begin
      btn_raw[1] = 1'b1;
      tick(6);
      check("tog_press", 32'(btn_press), 32'h02);
`ifdef BTN_DEBOUNCE_TOGGLE_EN
      check("tog_before", 32'(btn_toggle[1]), 32'((p % 2 == 0) ? 0 : 1));
      tick(1);
      check("tog_after", 32'(btn_toggle[1]), 32'((p % 2 == 0) ? 1 : 0));
`else
      tick(1);
`endif
      btn_raw[1] = 1'b0;
      tick(8);
    end

    // Random bouncing with hold times around the debounce threshold, occasional resets
    for (int i = 0; i < N; i++) hold[i] = $urandom_range(1, 2 * DC);
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        tick($urandom_range(1, 3));
        rst_n = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        if (hold[i] == 0) begin
          btn_raw[i] = ~btn_raw[i];
          hold[i] = $urandom_range(1, 2 * DC);
        end else begin
          hold[i]--;
        end
      end
      tick(1);
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Conditioning stage directly upstream of the board-level button-to-LED passthrough.
- Synchronises the raw ULX3S btn[6:0] pins to clk_25mhz and normalises polarity so that asserted always reads 1.
- Debounces each button with its own stable-time counter.
- Outputs a clean level vector that drives led[6:0] directly, plus one-cycle press/release strobes for future consumers.

Parameters:
- N_BTN, 7: number of buttons handled.
- DEBOUNCE_CYCLES, 250000: consecutive cycles a new level must persist before it is accepted (10 ms at 25 MHz). Minimum legal value 2.
- ACTIVE_LOW_MASK, 7'b0000001: bit i = 1 means btn_raw[i] is active-low. btn[0] is the active-low PWR button.

Ports:
- clk_25mhz  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- btn_raw  input  N_BTN  asynchronous button pins.
- btn_level  output  N_BTN  debounced level, 1 = pressed; drives led[N_BTN-1:0].
- btn_press  output  N_BTN  one-cycle strobe on an accepted 0->1 level change.
- btn_release  output  N_BTN  one-cycle strobe on an accepted 1->0 level change.

Behaviour:
- Reset, sampled on clk_25mhz while rst_n=0:
  - both synchroniser stages load ACTIVE_LOW_MASK, so the normalised sample reads idle;
  - counters are cleared to 0;
  - btn_level, btn_press and btn_release are all 0.
- Synchroniser: two flip-flop stages per bit, no combinational path from btn_raw to any output.
- Normalised sample: s[i] = sync2[i] XOR ACTIVE_LOW_MASK[i].
- Counter width: $clog2(DEBOUNCE_CYCLES). There is one independent counter per button; buttons never interact.
- Per-button two-state FSM. The state is btn_level[i] itself, with states IDLE(0) and PRESSED(1).
  - If s[i] == btn_level[i]: counter cleared to 0. Any glitch shorter than DEBOUNCE_CYCLES is fully forgotten.
  - If s[i] != btn_level[i] and counter != DEBOUNCE_CYCLES-1: counter increments.
  - If s[i] != btn_level[i] and counter == DEBOUNCE_CYCLES-1: btn_level[i] <= s[i], counter <= 0, and the matching strobe is set for exactly the next cycle.
- Strobe timing:
  - btn_press[i] / btn_release[i] are registered, high for one cycle only.
  - A strobe coincides with the first cycle in which btn_level[i] shows the new value.
  - btn_press and btn_release are never high together for the same bit.
- Latency: a clean raw transition first captured by sync1 on edge E appears on btn_level on edge E+DEBOUNCE_CYCLES+1. With DEBOUNCE_CYCLES=250000 this is about 10.00004 ms.
- Counter saturation: the counter never reaches DEBOUNCE_CYCLES, so there is no wrap-around.
- Reset mid-count: the pending change is discarded with no strobe, btn_level returns to 0 and the count restarts.
- Button held through reset: after rst_n rises, the press is reported as a normal press (level plus btn_press) after the standard latency.
- Simultaneous transitions on several buttons: each bit is handled independently, and multiple strobe bits may be high in the same cycle.
- Raw level bouncing exactly every DEBOUNCE_CYCLES-1 cycles: no change is ever accepted.

Optional Feature:
- Macro: BTN_DEBOUNCE_TOGGLE_EN.
- Defined:
  - adds output port btn_toggle [N_BTN-1:0], reset 0;
  - btn_toggle[i] inverts on the cycle after btn_press[i] is high, i.e. one cycle after the strobe;
  - btn_release has no effect on it;
  - used for latching LED on/off per button.
- Undefined: the port and its registers are absent, and all other behaviour is identical.

Test Plan:
- Bench setup: DEBOUNCE_CYCLES=4, ACTIVE_LOW_MASK=7'b0000001.
- Reset: hold rst_n=0 for 3 cycles with btn_raw=7'b0000001 -> btn_level=0, btn_press=0, btn_release=0 throughout and for 6 cycles after release.
- Clean press: btn_raw[3] 0->1 captured on edge E -> btn_level[3]=1 from edge E+5; btn_press[3]=1 for exactly that one cycle; led-facing level steady afterwards.
- Glitch reject: btn_raw[2] high for 3 cycles then low -> btn_level stays 0 and no strobes. Repeat with 4 cycles high -> accepted, btn_press[2] pulse, then btn_release[2] pulse after the fall.
- Active-low button: btn_raw[0] 1->0 -> btn_level[0]=1 after 5 edges with btn_press[0]; btn_raw[0] 0->1 -> btn_release[0] and btn_level[0]=0.
- Simultaneous and reset mid-count: btn_raw[6:4] all rise together -> btn_press=7'b1110000 in a single cycle. Separately, assert rst_n=0 two cycles into a count -> no strobe; the held button reports a press after deassert plus 5 edges.
- Toggle, with BTN_DEBOUNCE_TOGGLE_EN defined: press/release btn[1] three times -> btn_toggle[1] sequence 1,0,1, each change one cycle after btn_press[1].
